// File: rtl/tft43_pkg.sv
// Shared types and constants for the TFT43 power-up / full-screen fill controller.
// Covers state encoding, timing-engine trigger codes and address-window command words.
package tft43_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HW_RST,
        INIT,
        WIN,
        GRAM,
        FILL,
        READY,
        ERROR
    } state_t;

    localparam logic [1:0] TRG_RST     = 2'b00;
    localparam logic [1:0] TRG_CMD     = 2'b01;
    localparam logic [1:0] TRG_DATA    = 2'b10;
    localparam logic [1:0] TRG_CMDDATA = 2'b11;

    localparam logic [15:0] CMD_CASET = 16'h2A00;
    localparam logic [15:0] CMD_PASET = 16'h2B00;
    localparam logic [15:0] CMD_RAMWR = 16'h2C00;

    localparam int WIN_WORDS = 8;
    localparam int PIX_W     = 18;

    typedef struct packed {
        logic [1:0]  trigger;
        logic [15:0] data1;
        logic [15:0] data2;
    } tm_txn_t;

    // Words 0..3 set the column window, 4..7 the row window; each starts at 0.
    function automatic tm_txn_t win_txn(input logic [2:0]  idx,
                                        input logic [15:0] last_col,
                                        input logic [15:0] last_row);
        logic [15:0] lim;
        tm_txn_t     t;
        lim       = idx[2] ? last_row : last_col;
        t.trigger = TRG_CMDDATA;
        t.data1   = (idx[2] ? CMD_PASET : CMD_CASET) | {14'h0000, idx[1:0]};
        case (idx[1:0])
            2'd2:    t.data2 = {8'h00, lim[15:8]};
            2'd3:    t.data2 = {8'h00, lim[7:0]};
            default: t.data2 = 16'h0000;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/tft43_init_fill_ctrl_if.sv
// Handshake bundle between the controller and the LCD bus timing engine.
// The controller is the master; the timing engine answers with tm_done.
interface tft43_init_fill_ctrl_if;

    logic        tm_en;
    logic [1:0]  tm_trigger;
    logic [15:0] tm_data1;
    logic [15:0] tm_data2;
    logic        tm_done;

    modport master (
        output tm_en, tm_trigger, tm_data1, tm_data2,
        input  tm_done
    );

    modport slave (
        input  tm_en, tm_trigger, tm_data1, tm_data2,
        output tm_done
    );

endinterface

// File: rtl/tft43_init_rom.sv
// Power-up register table for the panel controller: index -> {cmd[15:0], data[15:0]}.
// Purely combinational; slots past the populated table read back as a NOP pair.
module tft43_init_rom #(
    parameter int INIT_LEN = 16,
    parameter int IDX_W    = 4
) (
    input  logic [IDX_W-1:0] idx,
    output logic [31:0]      entry
);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        entry = 32'h0000_0000;
        if (int'(idx) < INIT_LEN) begin
            case (int'(idx))
                0:       entry = {16'h0100, 16'h0000};
                1:       entry = {16'h1100, 16'h0000};
                2:       entry = {16'hE200, 16'h0023};
                3:       entry = {16'hE201, 16'h0002};
                4:       entry = {16'hE202, 16'h0054};
                5:       entry = {16'hE000, 16'h0001};
                6:       entry = {16'hE000, 16'h0003};
                7:       entry = {16'hE600, 16'h0001};
                8:       entry = {16'hE601, 16'h0033};
                9:       entry = {16'hE602, 16'h0032};
                10:      entry = {16'hB000, 16'h0000};
                11:      entry = {16'hB400, 16'h0002};
                12:      entry = {16'hB600, 16'h0001};
                13:      entry = {16'h3600, 16'h0000};
                14:      entry = {16'hF000, 16'h0003};
                15:      entry = {16'h2900, 16'h0000};
                default: entry = 32'h0000_0000;
            endcase
        end
    end

endmodule

// File: rtl/tft43_init_fill_ctrl.sv
// Sequences panel hardware reset, the init table, and full-screen RGB565 fills
// through a one-transaction-at-a-time timing engine, with a done timeout.
module tft43_init_fill_ctrl
    import tft43_pkg::*;
#(
    parameter int INIT_LEN  = 16,
    parameter int H_RES     = 480,
    parameter int V_RES     = 272,
    parameter int TO_CYCLES = 4096
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          fill_req,
    input  logic [15:0]                   fill_color,
    tft43_init_fill_ctrl_if.master        tm,
    output logic                          busy,
    output logic                          init_done,
    output logic                          fill_done,
    output logic                          err
);

    localparam int IDX_W = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;
    localparam int TO_W  = $clog2(TO_CYCLES + 1);

    localparam logic [PIX_W-1:0] LAST_INIT = PIX_W'(INIT_LEN - 1);
    localparam logic [PIX_W-1:0] LAST_WIN  = PIX_W'(WIN_WORDS - 1);
    localparam logic [PIX_W-1:0] LAST_PIX  = PIX_W'(H_RES * V_RES - 1);
    localparam logic [15:0]      LAST_COL  = 16'(H_RES - 1);
    localparam logic [15:0]      LAST_ROW  = 16'(V_RES - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_CYCLES - 1);

    state_t           state_q,     state_d;
    logic             tm_en_q,     tm_en_d;
    tm_txn_t          txn_q,       txn_d;
    logic [15:0]      color_q,     color_d;
    logic [PIX_W-1:0] cnt_q,       cnt_d;
    logic [TO_W-1:0]  to_cnt_q,    to_cnt_d;
    logic             init_done_q, init_done_d;
    logic             fill_done_q, fill_done_d;
    logic             err_q,       err_d;

    tm_txn_t     launch_txn;
    logic        issuing;
    logic [31:0] rom_entry;

    tft43_init_rom #(
        .INIT_LEN (INIT_LEN),
        .IDX_W    (IDX_W)
    ) u_init_rom (
        .idx   (cnt_q[IDX_W-1:0]),
        .entry (rom_entry)
    );

    // Transaction the current state would launch next; cnt_q selects the word.
    always_comb begin
        launch_txn = '{trigger: TRG_RST, data1: 16'h0000, data2: 16'h0000};
        issuing    = 1'b1;
        case (state_q)
            HW_RST:  launch_txn = '{trigger: TRG_RST, data1: 16'h0000, data2: 16'h0000};
            INIT:    launch_txn = '{trigger: TRG_CMDDATA, data1: rom_entry[31:16], data2: rom_entry[15:0]};
            WIN:     launch_txn = win_txn(cnt_q[2:0], LAST_COL, LAST_ROW);
            GRAM:    launch_txn = '{trigger: TRG_CMD, data1: CMD_RAMWR, data2: 16'h0000};
            FILL:    launch_txn = '{trigger: TRG_DATA, data1: color_q, data2: 16'h0000};
            default: issuing    = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        tm_en_d     = tm_en_q;
        txn_d       = txn_q;
        color_d     = color_q;
        cnt_d       = cnt_q;
        to_cnt_d    = to_cnt_q;
        init_done_d = init_done_q;
        fill_done_d = 1'b0;
        err_d       = err_q;

        if (tm_en_q) begin
            if (tm.tm_done) begin
                // Dropping tm_en here guarantees one low cycle before the next launch.
                tm_en_d = 1'b0;
                cnt_d   = cnt_q + 1'b1;
                case (state_q)
                    HW_RST: begin
                        state_d = INIT;
                        cnt_d   = '0;
                    end
                    INIT: if (cnt_q == LAST_INIT) begin
                        state_d     = READY;
                        init_done_d = 1'b1;
                        cnt_d       = '0;
                    end
                    WIN: if (cnt_q == LAST_WIN) begin
                        state_d = GRAM;
                        cnt_d   = '0;
                    end
                    GRAM: begin
                        state_d = FILL;
                        cnt_d   = '0;
                    end
                    FILL: if (cnt_q == LAST_PIX) begin
                        state_d     = READY;
                        fill_done_d = 1'b1;
                        cnt_d       = '0;
                    end
                    default: ;
                endcase
            end else if (to_cnt_q == TO_LAST) begin
                tm_en_d = 1'b0;
                err_d   = 1'b1;
                state_d = ERROR;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_d = HW_RST;
                    cnt_d   = '0;
                end
                // fill_req wins over start here because start is only honoured in IDLE.
                READY: if (fill_req) begin
                    state_d = WIN;
                    color_d = fill_color;
                    cnt_d   = '0;
                end
                default: if (issuing) begin
                    tm_en_d  = 1'b1;
                    txn_d    = launch_txn;
                    to_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            tm_en_q     <= 1'b0;
            txn_q       <= '0;
            color_q     <= '0;
            cnt_q       <= '0;
            to_cnt_q    <= '0;
            init_done_q <= 1'b0;
            fill_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tm_en_q     <= tm_en_d;
            txn_q       <= txn_d;
            color_q     <= color_d;
            cnt_q       <= cnt_d;
            to_cnt_q    <= to_cnt_d;
            init_done_q <= init_done_d;
            fill_done_q <= fill_done_d;
            err_q       <= err_d;
        end
    end

    assign tm.tm_en      = tm_en_q;
    assign tm.tm_trigger = txn_q.trigger;
    assign tm.tm_data1   = txn_q.data1;
    assign tm.tm_data2   = txn_q.data2;

    assign busy      = !(state_q inside {IDLE, READY, ERROR});
    assign init_done = init_done_q;
    assign fill_done = fill_done_q;
    assign err       = err_q;

endmodule
